// File: rtl/sbox_share_arb.sv
// Two-requester arbiter sharing one AES S-box between SubBytes and key expansion.
// Define SBOX_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module sbox_share_arb #(
    parameter int SBOX_LAT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic [7:0] data0_i,
    input  logic       decrypt0_i,
    input  logic [7:0] data1_i,
    input  logic       decrypt1_i,
    output logic [1:0] ack_o,
    output logic [7:0] data_o,
    output logic [1:0] grant_o,
    output logic       busy_o,
    output logic [7:0] sbox_data_o,
    output logic       sbox_decrypt_o,
    input  logic [7:0] sbox_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [1:0] cnt;
    logic       win;
    logic [1:0] grant;
    logic [1:0] ack;
    logic [7:0] data;
    logic [7:0] sbox_data;
    logic       sbox_decrypt;

`ifdef SBOX_ARB_FIXED_PRIO_EN
    always_comb begin
        win = ~req_i[0];
    end
`else
    logic last_grant;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        win = req_i[1];
        if (req_i == 2'b11) win = ~last_grant;
    end
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (|req_i) state_n = BUSY;
            BUSY:    if (cnt == 2'd0) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 2'd0;
            grant        <= 2'b00;
            ack          <= 2'b00;
            data         <= 8'h00;
            sbox_data    <= 8'h00;
            sbox_decrypt <= 1'b0;
`ifndef SBOX_ARB_FIXED_PRIO_EN
            last_grant   <= 1'b1;
`endif
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (|req_i) begin
                        grant        <= win ? 2'b10 : 2'b01;
                        sbox_data    <= win ? data1_i : data0_i;
                        sbox_decrypt <= win ? decrypt1_i : decrypt0_i;
                        cnt          <= 2'(SBOX_LAT);
`ifndef SBOX_ARB_FIXED_PRIO_EN
                        last_grant   <= win;
`endif
                    end
                end
                BUSY: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        data <= sbox_data_i;
                        ack  <= grant;
                    end
                end
                RESP: begin
                    ack   <= 2'b00;
                    grant <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign ack_o          = ack;
    assign data_o         = data;
    assign grant_o        = grant;
    assign busy_o         = (state != IDLE);
    assign sbox_data_o    = sbox_data;
    assign sbox_decrypt_o = sbox_decrypt;

endmodule

// File: tb/tb_sbox_share_arb.sv
// Bench for sbox_share_arb: a latency-0 and a latency-2 instance sharing stimulus,
// each fed by a mock S-box, with a queue of expected results checked on ack.
module tb_sbox_share_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [7:0] data0, data1;
    logic       dec0, dec1;

    logic [1:0] ack_a, grant_a, ack_b, grant_b;
    logic [7:0] data_a, sbd_a, sbi_a, data_b, sbd_b, sbi_b;
    logic       busy_a, sbc_a, busy_b, sbc_b;
    logic [7:0] pipe1, pipe2;

    logic       sel;
    logic [1:0] ack_s, grant_s;
    logic [7:0] data_s, sbd_s;
    logic       busy_s, sbc_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] g;
        logic [7:0] d;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Stand-in substitution: distinct forward and inverse mappings,
    // chosen so 0x53 -> 0xED forward and 0xED -> 0x53 inverse.
    function automatic logic [7:0] mock(input logic [7:0] x, input logic d);
        return d ? ({x[3:0], x[7:4]} ^ 8'h8D) : (x ^ 8'hBE);
    endfunction

    assign sbi_a = mock(sbd_a, sbc_a);

    always_ff @(posedge clk) begin
        pipe1 <= mock(sbd_b, sbc_b);
        pipe2 <= pipe1;
    end
    assign sbi_b = pipe2;

    sbox_share_arb #(.SBOX_LAT(0)) dut_a (
        .clk(clk), .reset(reset), .req_i(req),
        .data0_i(data0), .decrypt0_i(dec0),
        .data1_i(data1), .decrypt1_i(dec1),
        .ack_o(ack_a), .data_o(data_a), .grant_o(grant_a), .busy_o(busy_a),
        .sbox_data_o(sbd_a), .sbox_decrypt_o(sbc_a), .sbox_data_i(sbi_a)
    );

    sbox_share_arb #(.SBOX_LAT(2)) dut_b (
        .clk(clk), .reset(reset), .req_i(req),
        .data0_i(data0), .decrypt0_i(dec0),
        .data1_i(data1), .decrypt1_i(dec1),
        .ack_o(ack_b), .data_o(data_b), .grant_o(grant_b), .busy_o(busy_b),
        .sbox_data_o(sbd_b), .sbox_decrypt_o(sbc_b), .sbox_data_i(sbi_b)
    );

    assign ack_s   = sel ? ack_b   : ack_a;
    assign grant_s = sel ? grant_b : grant_a;
    assign data_s  = sel ? data_b  : data_a;
    assign sbd_s   = sel ? sbd_b   : sbd_a;
    assign busy_s  = sel ? busy_b  : busy_a;
    assign sbc_s   = sel ? sbc_b   : sbc_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ack"}, ack_s, 2'b00);
        chk({tag, "_grant"}, grant_s, 2'b00);
        chk({tag, "_busy"}, busy_s, 1'b0);
        chk({tag, "_data"}, data_s, 8'h00);
        chk({tag, "_sbox_data"}, sbd_s, 8'h00);
        chk({tag, "_sbox_dec"}, sbc_s, 1'b0);
    endtask

    // Drive one request pattern in an IDLE cycle and follow it to ack and back.
    task automatic xact(input logic [1:0] r,
                        input logic [7:0] d0, input logic c0,
                        input logic [7:0] d1, input logic c1,
                        input logic [1:0] eg, input int lat,
                        input logic hold, input logic corrupt);
        logic [7:0] op;
        logic       opd;
        exp_t       e;
        int         n;
        req = r; data0 = d0; dec0 = c0; data1 = d1; dec1 = c1;
        op  = eg[1] ? d1 : d0;
        opd = eg[1] ? c1 : c0;
        sb.push_back('{g: eg, d: mock(op, opd)});
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (grant_s == 2'b00 && n < 8);
        chk("grant", grant_s, eg);
        chk("sbox_data", sbd_s, op);
        chk("sbox_dec", sbc_s, opd);
        chk("busy", busy_s, 1'b1);
        if (corrupt) begin
            data0 = ~d0; data1 = ~d1; dec0 = ~c0; dec1 = ~c1;
        end
        n = 0;
        while (ack_s == 2'b00 && n < 8) begin
            @(posedge clk); #1; n++;
            if (ack_s == 2'b00) chk("sbox_hold", sbd_s, op);
        end
        chk("ack_latency", n, lat + 1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("ack", ack_s, e.g);
            chk("result", data_s, e.d);
        end
        chk("grant_resp", grant_s, eg);
        if (!hold) req = 2'b00;
        @(posedge clk); #1;
        chk("ack_clear", ack_s, 2'b00);
        chk("grant_clear", grant_s, 2'b00);
        chk("busy_clear", busy_s, 1'b0);
    endtask

    initial begin
        logic [1:0] g [4];
        int         n;
        int         seen;
`ifdef SBOX_ARB_FIXED_PRIO_EN
        g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        sel = 1'b0;
        reset = 1'b1;
        req = 2'b11; data0 = 8'h11; dec0 = 1'b0; data1 = 8'h22; dec1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("rst_a");
        sel = 1'b1;
        #1;
        chk_idle_outputs("rst_b");
        sel = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 4; i++)
            xact(2'b11, 8'h11, 1'b0, 8'h22, 1'b1, g[i], 0, 1'b1, 1'b0);

        xact(2'b01, 8'h53, 1'b0, 8'h00, 1'b0, 2'b01, 0, 1'b0, 1'b0);
        xact(2'b10, 8'h00, 1'b0, 8'hED, 1'b1, 2'b10, 0, 1'b0, 1'b0);

        req = 2'b00;
        repeat (8) @(posedge clk);
        #1;
        sel = 1'b1;
        xact(2'b01, 8'h53, 1'b0, 8'h00, 1'b0, 2'b01, 2, 1'b0, 1'b1);
        xact(2'b10, 8'h00, 1'b0, 8'hA7, 1'b1, 2'b10, 2, 1'b0, 1'b0);

        req = 2'b01; data0 = 8'h9A; dec0 = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (grant_s == 2'b00 && n < 8);
        chk("abort_grant", grant_s, 2'b01);
        reset = 1'b1;
        req = 2'b00;
        @(posedge clk); #1;
        chk_idle_outputs("abort");
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack_s != 2'b00) seen++;
        end
        chk("abort_no_ack", seen, 0);
        xact(2'b11, 8'h3C, 1'b0, 8'hC3, 1'b1, 2'b01, 2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
